// File: rtl/tx_channel_arbiter.sv
// Round-robin arbiter sharing one TX_channel transmit path among NREQ burst requesters.
// A grant lasts until the grantee's last beat or MAX_BEATS accepted beats, whichever comes first.
module tx_channel_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BEATS = 16
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  input  logic [NREQ-1:0]         req_last,
  output logic [NREQ-1:0]         req_ready,
  output logic [WIDTH-1:0]        tx_data,
  output logic                    tx_en,
  input  logic                    tx_hold,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic [7:0]              beat_count
);
  localparam int IDW = $clog2(NREQ);

  typedef enum logic [1:0] {IDLE, ARB, XFER} state_t;

  state_t         state;
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] next_ptr;
  logic           win_found;
  logic           g_valid;
  logic           g_last;
  logic           in_xfer;
  logic           accept;
  logic           rel_grant;
  logic [7:0]     beat_next;

  // Rotated priority search: walking k downward lets the lowest offset from ptr win.
  always_comb begin
    int             sum;
    logic [IDW-1:0] idx;
    sum       = 0;
    idx       = '0;
    win_found = 1'b0;
    win_id    = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = (int'(ptr) + k) % NREQ;
      idx = IDW'(sum);
      if (req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  always_comb begin
    tx_data = req_data[WIDTH-1:0];
    g_valid = 1'b0;
    g_last  = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) begin
        tx_data = req_data[i*WIDTH +: WIDTH];
        g_valid = req_valid[i];
        g_last  = req_last[i];
      end
    end
  end

  assign in_xfer   = (state == XFER);
  assign busy      = in_xfer;
  assign tx_en     = in_xfer & g_valid;
  assign accept    = tx_en & ~tx_hold;
  assign beat_next = beat_count + 8'd1;
  assign rel_grant = accept & (g_last | (beat_next == 8'(MAX_BEATS)));
  assign next_ptr  = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_id == IDW'(i)) req_ready[i] = accept;
    end
  end

  // Control state: ptr moves only on release, grant_id only on a successful ARB.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state      <= IDLE;
      ptr        <= '0;
      grant_id   <= '0;
      beat_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) state <= ARB;
        end
        ARB: begin
          if (win_found) begin
            grant_id   <= win_id;
            beat_count <= '0;
            state      <= XFER;
          end else begin
            state <= IDLE;
          end
        end
        XFER: begin
          if (accept) begin
            beat_count <= beat_next;
            if (rel_grant) begin
              state <= IDLE;
              ptr   <= next_ptr;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/tx_channel_arbiter.md
# tx_channel_arbiter

Round-robin arbiter that shares one `TX_channel` transmit path among `NREQ` requesters. Each requester presents a burst of `WIDTH`-bit beats terminated by a last flag. The arbiter grants one requester at a time, forwards its beats to `TX_channel` via the `tx_en`/`tx_hold` handshake, and holds the grant until the burst completes or a beat cap is reached. It sits between the upstream data sources and the `TX_channel` instance in the transmit path.

## Interface
- `WIDTH`, 8: data beat width; matches the `TX_channel` `WIDTH`.
- `NREQ`, 4: number of requesters; legal range 2–8.
- `MAX_BEATS`, 16: maximum beats per grant before forced release; legal range 1–255.
- `ACLK` input 1: clock; all state updates on the rising edge.
- `ARESETn` input 1: reset; asynchronous, active-low.
- `req_valid` input `NREQ`: requester `i` has a beat on `req_data` slice `i`.
- `req_data` input `NREQ*WIDTH`: beat data; requester `i` occupies bits `[i*WIDTH +: WIDTH]`.
- `req_last` input `NREQ`: the current beat of requester `i` is the final beat of its burst.
- `req_ready` output `NREQ`: beat of requester `i` is accepted at this rising edge.
- `tx_data` output `WIDTH`: data to `TX_channel`.
- `tx_en` output 1: `tx_data` is valid for `TX_channel`.
- `tx_hold` input 1: `TX_channel` is holding a prior beat and cannot accept new data.
- `grant_id` output `$clog2(NREQ)`: index of the current or most recent grantee.
- `busy` output 1: a grant is active.
- `beat_count` output 8: beats accepted in the current grant.

## Operation
- States:
  - `IDLE`: no grant.
  - `ARB`: one-cycle winner selection.
  - `XFER`: grant active.
- `IDLE` → `ARB` when any `req_valid` bit is 1. Otherwise stay in `IDLE`.
- `ARB`:
  - Select the first requester with `req_valid=1`, searching upward from `ptr` and wrapping modulo `NREQ`.
  - Register the winner into `grant_id`, clear `beat_count`, go to `XFER`.
  - If no `req_valid` bit is set in the `ARB` cycle (request withdrawn), return to `IDLE` and leave `grant_id` unchanged.
- `XFER` datapath, with `g = grant_id` (combinational):
  - `tx_en = req_valid[g]`
  - `tx_data = req_data[g]`
  - `req_ready[g] = req_valid[g] & ~tx_hold`
  - All other `req_ready` bits are 0.
- Beat acceptance is `tx_en & ~tx_hold` at a rising edge. On each accepted beat, `beat_count` increments (8-bit, never exceeds `MAX_BEATS`).
- Release condition: an accepted beat with `req_last[g]=1`, or an accepted beat that brings `beat_count` to `MAX_BEATS`. Both in the same beat produce a single release.
- On release:
  - Go to `IDLE`.
  - Set `ptr` to `(g+1) mod NREQ`.
  - `beat_count` holds its final value until the next `ARB`.
- If the grantee drops `req_valid` during `XFER`, the grant is held: `tx_en=0`, no timeout. The grantee owns the channel until last or cap.
- `tx_hold=1` stalls the transfer. `req_ready` stays 0 and `tx_data`/`tx_en` follow the grantee; the requester must hold data stable while valid.
- `busy = (state == XFER)`.
- In `IDLE` and `ARB`: `tx_en=0`, `req_ready=0`, and `tx_data` = `req_data` slice at `grant_id`, which is don't-care for `TX_channel`.

## Timing
- Reset values (asynchronous, applied on `ARESETn` low):
  - `state=IDLE`, `ptr=0`, `grant_id=0`, `beat_count=0`.
  - Hence `tx_en=0`, `req_ready=0`, `busy=0`.
- Reset asserted mid-`XFER` aborts the burst immediately. No beat is accepted at or after the reset edge.
- Request-to-first-`tx_en` latency: request visible in `IDLE` at edge N, `ARB` at N+1, `tx_en=1` during cycle after N+2.
- Minimum gap between consecutive grants: 2 cycles (`IDLE` then `ARB`), giving a throughput of `MAX_BEATS/(MAX_BEATS+2)` for back-to-back capped bursts.
- `tx_en`, `tx_data`, `req_ready` are combinational from registered state plus requester/`tx_hold` inputs. There are no combinational paths from `tx_hold` to `tx_en`.
- `ptr` changes only on release. A withdrawn request in `ARB` does not advance it.

## Test plan
- Reset then single request:
  - Stimulus: `req_valid=4'b0100`, 3-beat burst `0xA1`, `0xA2`, `0xA3` (last on `0xA3`), `tx_hold=0`.
  - Required response: `tx_en` rises 2 cycles after the request; 3 accepted beats in order; `grant_id=2`; `busy` drops after `0xA3`; `ptr=3`.
- Round-robin fairness:
  - Stimulus: all 4 requesters assert continuous single-beat bursts.
  - Required response: grant order 0,1,2,3,0,1; each grant accepts exactly 1 beat.
- Backpressure:
  - Stimulus: `tx_hold=1` for 3 cycles mid-burst of requester 1 with `req_data` held at `0x5C`.
  - Required response: `req_ready[1]=0` and `tx_data=0x5C` throughout; beat accepted once on the first edge with `tx_hold=0`; `beat_count` increments once.
- Beat cap:
  - Stimulus: `MAX_BEATS=4`, requester 0 streams 6 beats with no last, requester 3 also requesting.
  - Required response: release after beat 4 with `beat_count=4`; requester 3 granted next; requester 0 re-granted after that for its remaining 2 beats.
- Withdrawal and stall:
  - Stimulus: requester 2 drops `req_valid` for 5 cycles mid-burst while requester 0 requests.
  - Required response: grant stays on 2 with `tx_en=0` for those 5 cycles; no grant to 0 until 2 sends last.
  - Stimulus: a request pulsed only in the `IDLE` cycle.
  - Required response: `ARB` returns to `IDLE`; `ptr` unchanged.
- Reset mid-burst:
  - Stimulus: `ARESETn` low during beat 2 of a 4-beat burst.
  - Required response: `tx_en=0`, `busy=0`, `beat_count=0`, `ptr=0` immediately (before the next edge).
